infer_frame_scheduler: RTL and testbench

//  Sequences the pixel stream from a host or DMA into the MNIST inference core (top). It frames
//  the stream into fixed-size images and holds a per-frame label FIFO so the core's frames can

---
 rtl/infer_frame_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_infer_frame_scheduler.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/infer_frame_scheduler.sv
// Frames a host pixel stream into fixed-size images for the inference core, tracks per-frame
// labels in a small FIFO, scores core results against them and runs a batch watchdog.
module infer_frame_scheduler #(
    parameter int unsigned PIXELS       = 784,
    parameter int unsigned NUM_FRAMES   = 1000,
    parameter int unsigned MAX_INFLIGHT = 2,
    parameter int unsigned TIMEOUT      = 4096,
    parameter int unsigned IDX_W        = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       s_data,
    input  logic [3:0]       s_label,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [7:0]       core_data,
    output logic             core_valid,
    input  logic [3:0]       core_pred,
    input  logic [7:0]       core_conf,
    input  logic             core_valid_out,
    output logic             res_valid,
    output logic [3:0]       res_pred,
    output logic [7:0]       res_conf,
    output logic [3:0]       res_label,
    output logic             res_hit,
    output logic [IDX_W-1:0] res_idx,
    output logic [IDX_W-1:0] hit_count,
    output logic             done,
    output logic [1:0]       err
);
    localparam int unsigned PixW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam int unsigned CntW = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned PtrW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int unsigned WdW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [PixW-1:0]  pix_cnt_q;
    logic [IDX_W-1:0] sent_q, scored_q, res_idx_q, hit_count_q;
    logic [CntW-1:0]  fifo_cnt_q;
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [3:0]       lbl_mem_q [MAX_INFLIGHT];
    logic [WdW-1:0]   wd_q;
    logic [7:0]       core_data_q, res_conf_q;
    logic [3:0]       res_pred_q, res_label_q;
    logic             core_valid_q, res_valid_q, res_hit_q, done_q;
    logic [1:0]       err_q;

    logic run, xfer, push, pop, hit, last_pop, wd_trip;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MAX_INFLIGHT - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // A new frame may only begin when a label slot is free; mid-frame beats never stall.
    assign run      = (state_q == StRun);
    assign s_ready  = run && (sent_q < IDX_W'(NUM_FRAMES)) &&
                      ((pix_cnt_q != '0) || (fifo_cnt_q < CntW'(MAX_INFLIGHT)));
    assign xfer     = s_valid && s_ready;
    assign push     = xfer && (pix_cnt_q == '0);
    assign pop      = run && core_valid_out && (fifo_cnt_q != '0);
    assign hit      = (core_pred == lbl_mem_q[rd_ptr_q]);
    assign last_pop = pop && (scored_q == IDX_W'(NUM_FRAMES - 1));
    assign wd_trip  = run && (fifo_cnt_q != '0) && !core_valid_out &&
                      (wd_q == WdW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pix_cnt_q    <= '0;
            sent_q       <= '0;
            scored_q     <= '0;
            fifo_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            for (int i = 0; i < int'(MAX_INFLIGHT); i++) lbl_mem_q[i] <= '0;
            wd_q         <= '0;
            core_data_q  <= '0;
            core_valid_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_pred_q   <= '0;
            res_conf_q   <= '0;
            res_label_q  <= '0;
            res_hit_q    <= 1'b0;
            res_idx_q    <= '0;
            hit_count_q  <= '0;
            done_q       <= 1'b0;
            err_q        <= '0;
        end else begin
            core_valid_q <= 1'b0;
            res_valid_q  <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q     <= StRun;
                        pix_cnt_q   <= '0;
                        sent_q      <= '0;
                        scored_q    <= '0;
                        fifo_cnt_q  <= '0;
                        wr_ptr_q    <= '0;
                        rd_ptr_q    <= '0;
                        wd_q        <= '0;
                        res_pred_q  <= '0;
                        res_conf_q  <= '0;
                        res_label_q <= '0;
                        res_hit_q   <= 1'b0;
                        res_idx_q   <= '0;
                        hit_count_q <= '0;
                        done_q      <= 1'b0;
                        err_q       <= '0;
                    end
                end
                StRun: begin
                    if (xfer) begin
                        core_data_q  <= s_data;
                        core_valid_q <= 1'b1;
                        if (pix_cnt_q == PixW'(PIXELS - 1)) begin
                            pix_cnt_q <= '0;
                            sent_q    <= sent_q + IDX_W'(1);
                        end else begin
                            pix_cnt_q <= pix_cnt_q + PixW'(1);
                        end
                    end
                    if (push) begin
                        lbl_mem_q[wr_ptr_q] <= s_label;
                        wr_ptr_q            <= ptr_inc(wr_ptr_q);
                    end
                    if (pop) begin
                        res_valid_q <= 1'b1;
                        res_pred_q  <= core_pred;
                        res_conf_q  <= core_conf;
                        res_label_q <= lbl_mem_q[rd_ptr_q];
                        res_hit_q   <= hit;
                        res_idx_q   <= scored_q;
                        scored_q    <= scored_q + IDX_W'(1);
                        hit_count_q <= hit_count_q + IDX_W'(hit);
                        rd_ptr_q    <= ptr_inc(rd_ptr_q);
                    end else if (core_valid_out) begin
                        err_q[1] <= 1'b1;
                    end
                    case ({push, pop})
                        2'b10:   fifo_cnt_q <= fifo_cnt_q + CntW'(1);
                        2'b01:   fifo_cnt_q <= fifo_cnt_q - CntW'(1);
                        default: fifo_cnt_q <= fifo_cnt_q;
                    endcase
                    if ((fifo_cnt_q != '0) && !core_valid_out) wd_q <= wd_q + WdW'(1);
                    else                                       wd_q <= '0;
                    // Timeout wins over everything else this cycle and flushes the label FIFO.
                    if (wd_trip) begin
                        err_q[0]   <= 1'b1;
                        state_q    <= StDone;
                        done_q     <= 1'b1;
                        fifo_cnt_q <= '0;
                        wr_ptr_q   <= '0;
                        rd_ptr_q   <= '0;
                        wd_q       <= '0;
                    end else if (last_pop) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign core_data  = core_data_q;
    assign core_valid = core_valid_q;
    assign res_valid  = res_valid_q;
    assign res_pred   = res_pred_q;
    assign res_conf   = res_conf_q;
    assign res_label  = res_label_q;
    assign res_hit    = res_hit_q;
    assign res_idx    = res_idx_q;
    assign hit_count  = hit_count_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_infer_frame_scheduler.sv
// Scoreboard bench for infer_frame_scheduler: a behavioural core answers frames, expected
// results are queued when the core answers and compared when res_valid fires.
module tb_infer_frame_scheduler;
    localparam int unsigned PIXELS       = 4;
    localparam int unsigned NUM_FRAMES   = 3;
    localparam int unsigned MAX_INFLIGHT = 2;
    localparam int unsigned TIMEOUT      = 16;
    localparam int unsigned IDX_W        = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [7:0]       s_data = '0;
    logic [3:0]       s_label = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [7:0]       core_data;
    logic             core_valid;
    logic [3:0]       core_pred;
    logic [7:0]       core_conf;
    logic             core_valid_out;
    logic             res_valid;
    logic [3:0]       res_pred;
    logic [7:0]       res_conf;
    logic [3:0]       res_label;
    logic             res_hit;
    logic [IDX_W-1:0] res_idx;
    logic [IDX_W-1:0] hit_count;
    logic             done;
    logic [1:0]       err;

    infer_frame_scheduler #(
        .PIXELS      (PIXELS),
        .NUM_FRAMES  (NUM_FRAMES),
        .MAX_INFLIGHT(MAX_INFLIGHT),
        .TIMEOUT     (TIMEOUT),
        .IDX_W       (IDX_W)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .s_data        (s_data),
        .s_label       (s_label),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .core_data     (core_data),
        .core_valid    (core_valid),
        .core_pred     (core_pred),
        .core_conf     (core_conf),
        .core_valid_out(core_valid_out),
        .res_valid     (res_valid),
        .res_pred      (res_pred),
        .res_conf      (res_conf),
        .res_label     (res_label),
        .res_hit       (res_hit),
        .res_idx       (res_idx),
        .hit_count     (hit_count),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]       label;
        logic [3:0]       pred;
        logic [7:0]       conf;
        logic             hit;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] hits;
    } exp_t;

    exp_t       sb_q [$];
    logic [3:0] lbl_q [$];
    logic [3:0] ans_q [$];
    exp_t       core_e, mon_e;
    logic [3:0] l_tmp, p_tmp;

    int total = 0;
    int bad   = 0;
    int core_beat = 0, pend = 0, ans_budget = 0, ans_delay = 0, wait_cnt = 0;
    int exp_idx = 0, exp_hits = 0, cv_beats = 0;
    bit spur_req = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Behavioural core: counts pixels, answers each full frame after ans_delay cycles.
    initial begin
        core_valid_out = 1'b0;
        core_pred      = '0;
        core_conf      = '0;
        forever begin
            @(negedge clk);
            core_valid_out = 1'b0;
            if (rst_n && core_valid) begin
                core_beat++;
                if (core_beat == int'(PIXELS)) begin
                    core_beat = 0;
                    pend++;
                end
            end
            if (spur_req) begin
                core_valid_out = 1'b1;
                core_pred      = 4'($urandom);
                spur_req       = 1'b0;
            end else if (pend > 0 && ans_budget > 0) begin
                if (wait_cnt >= ans_delay) begin
                    l_tmp = (lbl_q.size() > 0) ? lbl_q.pop_front() : 4'd0;
                    p_tmp = (ans_q.size() > 0) ? ans_q.pop_front() : l_tmp;
                    core_pred      = p_tmp;
                    core_conf      = 8'($urandom);
                    core_valid_out = 1'b1;
                    core_e.label = l_tmp;
                    core_e.pred  = p_tmp;
                    core_e.conf  = core_conf;
                    core_e.hit   = (p_tmp == l_tmp);
                    if (core_e.hit) exp_hits++;
                    core_e.idx   = IDX_W'(exp_idx);
                    core_e.hits  = IDX_W'(exp_hits);
                    exp_idx++;
                    sb_q.push_back(core_e);
                    pend--;
                    ans_budget--;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Monitor: core_valid one cycle after each transfer, and scored results vs the scoreboard.
    logic       xfer_prev = 1'b0;
    logic [7:0] data_prev = '0;
    always @(negedge clk) begin
        check("core_valid", core_valid, xfer_prev);
        if (xfer_prev) check("core_data", core_data, data_prev);
        if (core_valid) cv_beats++;
        xfer_prev = s_valid & s_ready & rst_n;
        data_prev = s_data;
        if (res_valid) begin
            if (sb_q.size() == 0) begin
                check("res_unexpected", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("res_pred", res_pred, mon_e.pred);
                check("res_conf", res_conf, mon_e.conf);
                check("res_label", res_label, mon_e.label);
                check("res_hit", res_hit, mon_e.hit);
                check("res_idx", res_idx, mon_e.idx);
                check("hit_count", hit_count, mon_e.hits);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bench_clear();
        sb_q.delete();
        lbl_q.delete();
        ans_q.delete();
        pend     = 0;
        core_beat = 0;
        wait_cnt = 0;
        exp_idx  = 0;
        exp_hits = 0;
        cv_beats = 0;
        spur_req = 1'b0;
    endtask

    task automatic do_start();
        bench_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] lbl, input logic [7:0] base, input int nbeats);
        for (int p = 0; p < nbeats; p++) begin
            int n   = 0;
            bit got = 1'b0;
            s_valid = 1'b1;
            s_data  = base + 8'(p);
            s_label = lbl;
            while (!got && n < 64) begin
                @(negedge clk);
                got = s_ready;
                tick();
                n++;
            end
            if (!got) begin
                check("send_timeout", 0, 1);
                s_valid = 1'b0;
                return;
            end
            if (p == 0) lbl_q.push_back(lbl);
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        check("done", done, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_core_valid"}, core_valid, 0);
        check({tag, "_core_data"}, core_data, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_idx"}, res_idx, 0);
        check({tag, "_hit_count"}, hit_count, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        check_zero("rst");
        rst_n = 1'b1;
        tick();
        s_valid = 1'b1;
        #1;
        check("idle_ready", s_ready, 0);
        s_valid = 1'b0;

        // Back-to-back frames, core answers immediately (result overlaps next frame's push).
        do_start();
        ans_q = '{4'd7, 4'd2, 4'd5};
        ans_budget = 1000;
        ans_delay  = 0;
        send_frame(4'd7, 8'h10, 4);
        send_frame(4'd2, 8'h20, 4);
        send_frame(4'd1, 8'h30, 4);
        wait_done(100);
        tick();
        check("t1_hits", hit_count, 2);
        check("t1_err", err, 0);
        check("t1_beats", cv_beats, 12);
        check("t1_done_ready", s_ready, 0);

        // Backpressure: two frames in flight, third frame waits for one result.
        do_start();
        ans_budget = 0;
        send_frame(4'd5, 8'h40, 4);
        send_frame(4'd3, 8'h50, 4);
        s_valid = 1'b1;
        s_label = 4'd9;
        s_data  = 8'h60;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready", s_ready, 0);
            tick();
        end
        ans_budget = 1;
        send_frame(4'd9, 8'h60, 4);
        @(negedge clk);
        check("bp_batch_full", s_ready, 0);
        tick();
        ans_budget = 1000;
        wait_done(100);
        tick();
        check("t2_hits", hit_count, 3);
        check("t2_err", err, 0);

        // Slow core: label FIFO sits full while the next frame waits.
        do_start();
        ans_q = '{4'd0, 4'd6, 4'd4};
        ans_budget = 1000;
        ans_delay  = 4;
        send_frame(4'd0, 8'h70, 4);
        send_frame(4'd6, 8'h80, 4);
        send_frame(4'd8, 8'h90, 4);
        wait_done(100);
        tick();
        check("t3_hits", hit_count, 2);
        check("t3_err", err, 0);

        // Spurious core result before any frame.
        do_start();
        ans_delay  = 0;
        ans_budget = 1000;
        spur_req   = 1'b1;
        repeat (3) tick();
        check("t4_err_spur", err, 2'b10);
        check("t4_not_done", done, 0);
        send_frame(4'd1, 8'hA0, 4);
        send_frame(4'd2, 8'hB0, 4);
        send_frame(4'd3, 8'hC0, 4);
        wait_done(100);
        tick();
        check("t4_err_end", err, 2'b10);
        check("t4_hits", hit_count, 3);

        // Watchdog: one frame, no result.
        do_start();
        ans_budget = 0;
        send_frame(4'd4, 8'hD0, 4);
        wait_done(60);
        check("t5_err", err, 2'b01);
        s_valid = 1'b1;
        #1;
        check("t5_ready", s_ready, 0);
        s_valid = 1'b0;
        do_start();
        check("t5_err_clr", err, 0);
        check("t5_done_clr", done, 0);
        ans_budget = 1000;
        send_frame(4'd5, 8'hE0, 4);
        send_frame(4'd6, 8'hE8, 4);
        send_frame(4'd7, 8'hF0, 4);
        wait_done(100);
        tick();
        check("t5_err_end", err, 0);

        // Reset in the middle of frame 0, then a clean batch.
        do_start();
        ans_budget = 1000;
        send_frame(4'd3, 8'h11, 2);
        rst_n = 1'b0;
        tick();
        check_zero("mid_rst");
        rst_n = 1'b1;
        tick();
        do_start();
        ans_budget = 1000;
        send_frame(4'd1, 8'h21, 4);
        send_frame(4'd2, 8'h31, 4);
        send_frame(4'd3, 8'h41, 4);
        wait_done(100);
        tick();
        check("t6_hits", hit_count, 3);
        check("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
